vga_sprite_engine: RTL and testbench

//  Parametrised VGA timing generator and N-channel rectangular sprite compositor. It drives the monitor port (sync, 8:8:8 RGB).

---
 rtl/vga_sprite_engine_pkg.sv | 24 ++
 rtl/vga_sprite_engine_timing.sv | 66 ++++++
 rtl/vga_sprite_engine.sv | 140 ++++++++++++++
 tb/tb_vga_sprite_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sprite_engine_pkg.sv
// rtl/vga_sprite_engine_pkg.sv - shared timing defaults, field offsets and widths
package vga_sprite_engine_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int COORD_W = 11;
    localparam int CMP_W   = 12;
    localparam int COLOR_W = 24;
    localparam int X_LSB   = 0;
    localparam int Y_LSB   = 16;

    // Widened so that coordinate + sprite size cannot wrap
    function automatic logic [CMP_W-1:0] ext(input logic [COORD_W-1:0] c);
        return {1'b0, c};
    endfunction

endpackage

// File: rtl/vga_sprite_engine_timing.sv
// rtl/vga_sprite_engine_timing.sv - pixel-tick divider, H/V counters and raw sync/active
module vga_sprite_engine_timing
    import vga_sprite_engine_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int PIX_DIV  = 4,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    output logic               o_tick,
    output logic [COORD_W-1:0] o_h,
    output logic [COORD_W-1:0] o_v,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_active
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DIV_W-1:0]   r_div;
    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;
    logic               w_tick;

    assign w_tick = i_en && (r_div == DIV_W'(PIX_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            if (i_en)
                r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                if (r_h == COORD_W'(H_TOT - 1)) begin
                    r_h <= '0;
                    r_v <= (r_v == COORD_W'(V_TOT - 1)) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    assign o_tick   = w_tick;
    assign o_h      = r_h;
    assign o_v      = r_v;
    assign o_hs     = (r_h >= COORD_W'(H_ACTIVE + H_FP) && r_h < COORD_W'(H_ACTIVE + H_FP + H_SYNC))
                      ? SYNC_ACT : ~SYNC_ACT;
    assign o_vs     = (r_v >= COORD_W'(V_ACTIVE + V_FP) && r_v < COORD_W'(V_ACTIVE + V_FP + V_SYNC))
                      ? SYNC_ACT : ~SYNC_ACT;
    assign o_active = (r_h < COORD_W'(H_ACTIVE)) && (r_v < COORD_W'(V_ACTIVE));

endmodule

// File: rtl/vga_sprite_engine.sv
// rtl/vga_sprite_engine.sv - VGA timing plus N-channel fixed-priority rectangular sprite compositor
module vga_sprite_engine
    import vga_sprite_engine_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D,
    parameter int PIX_DIV  = 4,
    parameter int N_SPR    = 11,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 16,
    parameter bit SYNC_ACT = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic [32*N_SPR-1:0]      i_spr_xy,
    input  logic [COLOR_W*N_SPR-1:0] i_spr_color,
    input  logic [N_SPR-1:0]         i_spr_en,
    input  logic [COLOR_W-1:0]       i_bg_color,
    output logic                     o_hs,
    output logic                     o_vs,
    output logic                     o_video_on,
    output logic [7:0]               o_red,
    output logic [7:0]               o_green,
    output logic [7:0]               o_blue,
    output logic                     o_frame_start,
    output logic [COORD_W-1:0]       o_hcount,
    output logic [COORD_W-1:0]       o_vcount
);

    logic               w_tick, w_hs, w_vs, w_active;
    logic [COORD_W-1:0] w_h, w_v;
    logic [N_SPR-1:0]   w_hit;
    logic [COLOR_W-1:0] w_pix;
    logic               w_latch;
    logic               w_unused_xy;

    logic [COORD_W-1:0] r_sh_x     [N_SPR];
    logic [COORD_W-1:0] r_sh_y     [N_SPR];
    logic [COLOR_W-1:0] r_sh_color [N_SPR];
    logic [N_SPR-1:0]   r_sh_en;

    logic [N_SPR-1:0]   r1_hit;
    logic               r1_active, r1_hs, r1_vs;
    logic [COLOR_W-1:0] r2_rgb;
    logic               r2_active, r2_hs, r2_vs;
    logic               r_frame_start;

    vga_sprite_engine_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PIX_DIV(PIX_DIV), .SYNC_ACT(SYNC_ACT)
    ) u_timing (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .o_tick(w_tick), .o_h(w_h), .o_v(w_v),
        .o_hs(w_hs), .o_vs(w_vs), .o_active(w_active)
    );

    assign w_unused_xy = ^i_spr_xy;

    // Shadows load at the start of vertical blanking, so a frame never sees a half-updated set
    assign w_latch = w_tick && (w_h == '0) && (w_v == COORD_W'(V_ACTIVE));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < N_SPR; i++) begin
                r_sh_x[i]     <= '0;
                r_sh_y[i]     <= '0;
                r_sh_color[i] <= '0;
            end
            r_sh_en <= '0;
        end else if (w_latch) begin
            for (int i = 0; i < N_SPR; i++) begin
                r_sh_x[i]     <= i_spr_xy[32*i+X_LSB +: COORD_W];
                r_sh_y[i]     <= i_spr_xy[32*i+Y_LSB +: COORD_W];
                r_sh_color[i] <= i_spr_color[COLOR_W*i +: COLOR_W];
            end
            r_sh_en <= i_spr_en;
        end
    end

    for (genvar i = 0; i < N_SPR; i++) begin : g_hit
        assign w_hit[i] = r_sh_en[i]
            && (ext(w_h) >= ext(r_sh_x[i])) && (ext(w_h) < ext(r_sh_x[i]) + CMP_W'(SPR_W))
            && (ext(w_v) >= ext(r_sh_y[i])) && (ext(w_v) < ext(r_sh_y[i]) + CMP_W'(SPR_H));
    end

    // Scan downward so the lowest-index hit is the final assignment
    always_comb begin
        w_pix = i_bg_color;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (r1_hit[i])
                w_pix = r_sh_color[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r1_hit        <= '0;
            r1_active     <= 1'b0;
            r1_hs         <= ~SYNC_ACT;
            r1_vs         <= ~SYNC_ACT;
            r2_rgb        <= '0;
            r2_active     <= 1'b0;
            r2_hs         <= ~SYNC_ACT;
            r2_vs         <= ~SYNC_ACT;
            r_frame_start <= 1'b0;
        end else begin
            if (i_en)
                r_frame_start <= w_tick && (w_h == '0) && (w_v == '0);
            if (w_tick) begin
                r1_hit    <= w_hit;
                r1_active <= w_active;
                r1_hs     <= w_hs;
                r1_vs     <= w_vs;
                r2_rgb    <= r1_active ? w_pix : '0;
                r2_active <= r1_active;
                r2_hs     <= r1_hs;
                r2_vs     <= r1_vs;
            end
        end
    end

    assign o_hs          = r2_hs;
    assign o_vs          = r2_vs;
    assign o_video_on    = r2_active;
    assign o_red         = r2_rgb[23:16];
    assign o_green       = r2_rgb[15:8];
    assign o_blue        = r2_rgb[7:0];
    assign o_frame_start = r_frame_start;
    assign o_hcount      = w_h;
    assign o_vcount      = w_v;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb/tb_vga_sprite_engine.sv - directed self-checking bench on a reduced 24x16 raster
module tb_vga_sprite_engine;

    localparam int N   = 4;
    localparam int PD  = 2;
    localparam logic [23:0] BG    = 24'h123456;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [32*N-1:0] spr_xy;
    logic [24*N-1:0] spr_color;
    logic [N-1:0]    spr_en;
    logic [23:0]     bg;
    logic            hs, vs, video_on, frame_start;
    logic [7:0]      red, green, blue;
    logic [10:0]     hcount, vcount;
    logic [23:0]     rgb;

    int n_cmp = 0;
    int n_err = 0;

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    vga_sprite_engine #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIX_DIV(PD), .N_SPR(N), .SPR_W(4), .SPR_H(3), .SYNC_ACT(1'b0)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_en(en),
        .i_spr_xy(spr_xy), .i_spr_color(spr_color), .i_spr_en(spr_en), .i_bg_color(bg),
        .o_hs(hs), .o_vs(vs), .o_video_on(video_on),
        .o_red(red), .o_green(green), .o_blue(blue),
        .o_frame_start(frame_start), .o_hcount(hcount), .o_vcount(vcount)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_spr(input int i, input int x, input int y, input logic [23:0] c);
        logic [10:0] xx, yy;
        xx = 11'(x);
        yy = 11'(y);
        spr_xy[32*i +: 32]    = {5'b0, yy, 5'b0, xx};
        spr_color[24*i +: 24] = c;
    endtask

    // Output shows pixel (h,v) while stage-0 sits at (h+2,v)
    task automatic goto_pix(input int h, input int v, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (hcount == 11'(h + 2) && vcount == 11'(v)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_px%0d_%0d: pixel never reached within 2000 clks", h, v);
        end
    endtask

    task automatic check_pix(input int h, input int v, input logic [23:0] e_rgb,
                             input logic e_vo, input logic e_hs, input logic e_vs);
        bit    ok;
        string t;
        t = $sformatf("px%0d_%0d", h, v);
        goto_pix(h, v, ok);
        if (ok) begin
            check_eq({t, "_rgb"}, 32'(rgb), 32'(e_rgb));
            check_eq({t, "_von"}, 32'(video_on), 32'(e_vo));
            check_eq({t, "_hs"}, 32'(hs), 32'(e_hs));
            check_eq({t, "_vs"}, 32'(vs), 32'(e_vs));
        end
    endtask

    task automatic wait_stage0(input int h, input int v);
        bit ok;
        goto_pix(h - 2, v, ok);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        en = 1'b1;
        spr_xy = '0;
        spr_color = '0;
        spr_en = '0;
        bg = BG;
        set_spr(0, 2, 1, RED);
        spr_en = 4'b0001;

        repeat (3) @(negedge clk);
        check_eq("rst_hs", 32'(hs), 32'd1);
        check_eq("rst_vs", 32'(vs), 32'd1);
        check_eq("rst_von", 32'(video_on), 32'd0);
        check_eq("rst_rgb", 32'(rgb), 32'd0);
        check_eq("rst_fs", 32'(frame_start), 32'd0);
        check_eq("rst_hcount", 32'(hcount), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("fs_early", 32'(frame_start), 32'd0);
        @(negedge clk);
        check_eq("fs_first_tick", 32'(frame_start), 32'd1);
        check_eq("h_after_first_tick", 32'(hcount), 32'd1);

        // Frame 0: shadows still cleared, so the enabled input sprite is not shown
        check_pix(2, 1, BG, 1, 1, 1);
        check_pix(16, 1, 0, 0, 1, 1);
        check_pix(17, 2, 0, 0, 1, 1);
        check_pix(18, 2, 0, 0, 0, 1);
        check_pix(20, 2, 0, 0, 0, 1);
        check_pix(21, 2, 0, 0, 1, 1);
        check_pix(15, 3, BG, 1, 1, 1);
        check_pix(0, 11, BG, 1, 1, 1);
        check_pix(0, 12, 0, 0, 1, 1);
        check_pix(0, 13, 0, 0, 1, 0);
        check_pix(0, 14, 0, 0, 1, 0);
        check_pix(0, 15, 0, 0, 1, 1);

        // Frame 1: spr0 covers h2..5, v1..3
        check_pix(2, 0, BG, 1, 1, 1);
        check_pix(1, 1, BG, 1, 1, 1);
        check_pix(2, 1, RED, 1, 1, 1);
        check_pix(6, 1, BG, 1, 1, 1);
        check_pix(5, 3, RED, 1, 1, 1);
        check_pix(2, 4, BG, 1, 1, 1);
        set_spr(3, 4, 2, BLUE);
        spr_en = 4'b1001;

        // Frame 2: spr3 covers h4..7, v2..4; spr0 wins the overlap
        check_pix(5, 1, RED, 1, 1, 1);
        check_pix(4, 2, RED, 1, 1, 1);
        check_pix(6, 2, BLUE, 1, 1, 1);
        check_pix(8, 2, BG, 1, 1, 1);
        check_pix(3, 3, RED, 1, 1, 1);
        check_pix(7, 4, BLUE, 1, 1, 1);
        check_pix(4, 5, BG, 1, 1, 1);
        set_spr(0, 9, 6, RED);
        set_spr(1, 14, 9, GREEN);
        set_spr(2, 20, 9, WHITE);
        spr_en = 4'b1111;
        check_pix(9, 6, BG, 1, 1, 1);
        check_pix(10, 7, BG, 1, 1, 1);

        // Frame 3: moved spr0, right-edge clipped spr1, off-screen spr2
        check_pix(2, 1, BG, 1, 1, 1);
        check_pix(6, 2, BLUE, 1, 1, 1);
        check_pix(9, 6, RED, 1, 1, 1);
        check_pix(12, 6, RED, 1, 1, 1);
        check_pix(13, 6, BG, 1, 1, 1);
        check_pix(13, 9, BG, 1, 1, 1);
        check_pix(14, 9, GREEN, 1, 1, 1);
        check_pix(15, 9, GREEN, 1, 1, 1);
        check_pix(16, 9, 0, 0, 1, 1);
        check_pix(21, 9, 0, 0, 1, 1);
        check_pix(15, 11, GREEN, 1, 1, 1);

        // Drive spr0 in the exact latch clk, then change it again one clk later
        wait_stage0(0, 12);
        @(negedge clk);
        set_spr(0, 4, 7, RED);
        @(negedge clk);
        check_eq("latch_tick_h", 32'(hcount), 32'd1);
        set_spr(0, 12, 7, RED);

        // Frame 4: spr0 at (4,7) covers h4..7, v7..9
        check_pix(9, 6, BG, 1, 1, 1);
        check_pix(3, 7, BG, 1, 1, 1);
        check_pix(4, 7, RED, 1, 1, 1);
        check_pix(7, 7, RED, 1, 1, 1);
        check_pix(8, 7, BG, 1, 1, 1);
        check_pix(12, 7, BG, 1, 1, 1);

        wait_stage0(7, 10);
        check_eq("pre_freeze_rgb", 32'(rgb), 32'(BG));
        en = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("freeze_h", 32'(hcount), 32'd7);
        check_eq("freeze_v", 32'(vcount), 32'd10);
        check_eq("freeze_rgb", 32'(rgb), 32'(BG));
        check_eq("freeze_von", 32'(video_on), 32'd1);
        en = 1'b1;
        k = 0;
        while (hcount == 11'd7 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check_eq("resume_h", 32'(hcount), 32'd8);

        // Frame 5: asynchronous reset in mid-frame
        wait_stage0(5, 7);
        check_eq("pre_rst_rgb", 32'(rgb), 32'(BG));
        rst_n = 1'b0;
        #1;
        check_eq("mrst_hs", 32'(hs), 32'd1);
        check_eq("mrst_vs", 32'(vs), 32'd1);
        check_eq("mrst_von", 32'(video_on), 32'd0);
        check_eq("mrst_rgb", 32'(rgb), 32'd0);
        check_eq("mrst_h", 32'(hcount), 32'd0);
        check_eq("mrst_v", 32'(vcount), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("mrst_fs_early", 32'(frame_start), 32'd0);
        @(negedge clk);
        check_eq("mrst_fs_first", 32'(frame_start), 32'd1);
        @(negedge clk);
        check_eq("fs_width", 32'(frame_start), 32'd0);
        @(negedge clk);
        check_eq("tick_period_h", 32'(hcount), 32'd2);
        k = 3;
        @(negedge clk);
        while (!frame_start && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check_eq("frame_period_clks", 32'(k), 32'd768);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
